// File: rtl/seg7_result_display.sv
// Calculator result display: sequential binary-to-BCD conversion (shift-and-add-3)
// feeding a 3-digit multiplexed active-low seven-segment display with sign digit.
module seg7_result_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned RESULT_W    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RESULT_W-1:0] res,
    input  logic                is_signed,
    output logic                busy,
    output logic [6:0]          seg,
    output logic [2:0]          an
);

    localparam int unsigned SH_W  = RESULT_W + 8;
    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                 state, state_nxt;
    logic [RESULT_W:0]      latched, latched_nxt;
    logic [SH_W-1:0]        shifter, shifter_nxt, step_c;
    logic [2:0]             count, count_nxt;
    logic                   neg, neg_nxt;
    logic [RESULT_W-1:0]    mag_c, inv_c;
    logic [3:0]             tens_c;
    logic [6:0]             disp0, disp1, disp2;
    logic [6:0]             disp0_nxt, disp1_nxt, disp2_nxt;

    logic [CNT_W-1:0]       refresh_cnt, refresh_nxt;
    logic [1:0]             idx, idx_nxt;
    logic [6:0]             seg_nxt;
    logic [2:0]             an_nxt;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    // One double-dabble step: correct BCD nibbles >= 5, then shift left
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
        logic [3:0]      t, o;
        logic [SH_W-1:0] tmp;
        t = s[SH_W-1 -: 4];
        o = s[RESULT_W+3 -: 4];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        tmp = {t, o, s[RESULT_W-1:0]};
        dd_step = tmp << 1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        latched_nxt = latched;
        shifter_nxt = shifter;
        count_nxt   = count;
        neg_nxt     = neg;
        disp0_nxt   = disp0;
        disp1_nxt   = disp1;
        disp2_nxt   = disp2;
        inv_c       = ~res;
        mag_c       = (is_signed && res[RESULT_W-1]) ? (inv_c + RESULT_W'(1)) : res;
        step_c      = dd_step(shifter);
        tens_c      = step_c[SH_W-1 -: 4];
        case (state)
            IDLE: begin
                if ({is_signed, res} != latched) begin
                    latched_nxt = {is_signed, res};
                    neg_nxt     = is_signed & res[RESULT_W-1];
                    shifter_nxt = {8'd0, mag_c};
                    count_nxt   = 3'd0;
                    state_nxt   = CONVERT;
                end
            end
            CONVERT: begin
                shifter_nxt = step_c;
                count_nxt   = count + 3'd1;
                // Final step commits all three digits together
                if (count == 3'(RESULT_W - 1)) begin
                    state_nxt = IDLE;
                    disp0_nxt = seg_of(step_c[RESULT_W+3 -: 4]);
                    disp1_nxt = (tens_c == 4'd0) ? SEG_BLANK : seg_of(tens_c);
                    disp2_nxt = neg ? SEG_MINUS : SEG_BLANK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latched <= '0;
            shifter <= '0;
            count   <= 3'd0;
            neg     <= 1'b0;
            busy    <= 1'b0;
            disp0   <= SEG_ZERO;
            disp1   <= SEG_BLANK;
            disp2   <= SEG_BLANK;
        end else begin
            latched <= latched_nxt;
            shifter <= shifter_nxt;
            count   <= count_nxt;
            neg     <= neg_nxt;
            busy    <= (state_nxt == CONVERT);
            disp0   <= disp0_nxt;
            disp1   <= disp1_nxt;
            disp2   <= disp2_nxt;
        end
    end

    // Digit scan; seg and an are computed from the same next index so they switch together
    always_comb begin
        refresh_nxt = refresh_cnt + CNT_W'(1);
        idx_nxt     = (idx == 2'd3) ? 2'd0 : idx;
        if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_nxt = '0;
            idx_nxt     = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
        end
        case (idx_nxt)
            2'd0:    seg_nxt = disp0;
            2'd1:    seg_nxt = disp1;
            default: seg_nxt = disp2;
        endcase
        an_nxt = ~(3'b001 << idx_nxt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
            seg         <= SEG_ZERO;
            an          <= 3'b110;
        end else begin
            refresh_cnt <= refresh_nxt;
            idx         <= idx_nxt;
            seg         <= seg_nxt;
            an          <= an_nxt;
        end
    end

endmodule
